// File: rtl/pm_entry_pkg.sv
// Shared definitions for the PM-entry sideband responders: message ids,
// FSM state encoding and the default timeout base.
package pm_entry_pkg;

  localparam int PM_MSG_REQ_L1  = 2;
  localparam int PM_MSG_REQ_L2  = 3;
  localparam int PM_MSG_RSP_NAK = 9;
  localparam int PM_MSG_RSP_L1  = 10;
  localparam int PM_MSG_RSP_L2  = 11;

  localparam int PM_TMO_BASE = 100;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_REQ = 2'b01,
    ST_SEND_RSP = 2'b11,
    ST_DONE     = 2'b10
  } pm_state_e;

endpackage

// File: rtl/pm_tmo_counter.sv
// Timeout counter: load clears the count and captures TMO_BASE << ratio as the
// limit; tc flags the last cycle before the limit is reached while running.
module pm_tmo_counter
  import pm_entry_pkg::*;
#(
  parameter int RATIO_W  = 2,
  parameter int CNT_W    = 12,
  parameter int TMO_BASE = PM_TMO_BASE
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               load,
  input  logic               run,
  input  logic [RATIO_W-1:0] ratio,
  output logic               tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] lim_q;

  // limit is frozen at load so ratio changes mid-count have no effect
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
      lim_q <= CNT_W'(TMO_BASE) << ratio;
    end else if (run) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tc = (cnt_q == lim_q - CNT_W'(1));

endmodule

// File: rtl/pm_entry_rx_gen.sv
// Remote PM-request responder: answers Req L1/L2 with Rsp or PMNAK over the
// sideband valid/done handshake. Optional PMNAK counter: PM_RX_NAK_CNT_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | local PM disabled; latched request times out into a PMNAK
// WAIT_REQ | local PM enabled, waiting for a latched remote request
// SEND_RSP | response on the sideband, valid held until done
// DONE     | flow finished, o_test_done high
module pm_entry_rx_gen
  import pm_entry_pkg::*;
#(
  parameter int MSG_W       = 4,
  parameter int RATIO_W     = 2,
  parameter int TMO_BASE    = PM_TMO_BASE,
  parameter int CNT_W       = 12,
  parameter int MSG_REQ_L1  = PM_MSG_REQ_L1,
  parameter int MSG_REQ_L2  = PM_MSG_REQ_L2,
  parameter int MSG_RSP_NAK = PM_MSG_RSP_NAK,
  parameter int MSG_RSP_L1  = PM_MSG_RSP_L1,
  parameter int MSG_RSP_L2  = PM_MSG_RSP_L2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_req_L1_or_L2,
  input  logic [RATIO_W-1:0] i_clk_div_ratio,
  input  logic               i_force_exit,
  input  logic               i_msg_valid,
  input  logic [MSG_W-1:0]   i_msg_no,
  input  logic               i_msg_done,
  output logic               o_msg_valid,
  output logic [MSG_W-1:0]   o_msg_no,
  output logic               o_test_done,
  output logic               o_nak_sent
`ifdef PM_RX_NAK_CNT_EN
  ,
  output logic [7:0]         o_nak_cnt
`endif
);

  pm_state_e        state_q, state_d;
  logic             lat_q, lat_kind_q;
  logic             rsp_nak_q, rsp_tmo_q;
  logic             issue, issue_nak, issue_tmo, lat_clr;
  logic [MSG_W-1:0] issue_no;
  logic             req_rx, nak_rx;
  logic             tmo_run, tmo_tc;

  assign req_rx = i_msg_valid && ((i_msg_no == MSG_W'(MSG_REQ_L1)) ||
                                  (i_msg_no == MSG_W'(MSG_REQ_L2)));
  assign nak_rx = i_msg_valid && (i_msg_no == MSG_W'(MSG_RSP_NAK));
  assign tmo_run = (state_q == ST_IDLE) && lat_q && !i_en;

  pm_tmo_counter #(
    .RATIO_W  (RATIO_W),
    .CNT_W    (CNT_W),
    .TMO_BASE (TMO_BASE)
  ) u_tmo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .load    (req_rx),
    .run     (tmo_run),
    .ratio   (i_clk_div_ratio),
    .tc      (tmo_tc)
  );

  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    issue_nak = 1'b0;
    issue_tmo = 1'b0;
    lat_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_en) begin
          state_d = ST_WAIT_REQ;
        end else if (lat_q && tmo_tc) begin
          issue     = 1'b1;
          issue_nak = 1'b1;
          issue_tmo = 1'b1;
        end
      end
      ST_WAIT_REQ: begin
        if (!i_en) begin
          state_d = ST_IDLE;
          lat_clr = 1'b1;
        end else if (lat_q) begin
          issue     = 1'b1;
          issue_nak = (lat_kind_q != i_req_L1_or_L2);
        end
      end
      ST_SEND_RSP: begin
        // a timeout PMNAK must complete even if the RDI side drops enable
        if (!i_en && !rsp_tmo_q) begin
          state_d = ST_IDLE;
        end else if (!o_msg_valid) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!i_en || rsp_nak_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (issue) begin
      state_d = ST_SEND_RSP;
      lat_clr = 1'b1;
    end
    issue_no = issue_nak  ? MSG_W'(MSG_RSP_NAK) :
               lat_kind_q ? MSG_W'(MSG_RSP_L2) : MSG_W'(MSG_RSP_L1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // a fresh request beats a same-cycle clear; late requests from SEND_RSP/DONE
  // survive the return to IDLE and are serviced from there
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lat_q      <= 1'b0;
      lat_kind_q <= 1'b0;
    end else if (req_rx) begin
      lat_q      <= 1'b1;
      lat_kind_q <= (i_msg_no == MSG_W'(MSG_REQ_L2));
    end else if (lat_clr) begin
      lat_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_msg_valid <= 1'b0;
      o_msg_no    <= '0;
      rsp_nak_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
      o_nak_sent  <= 1'b0;
      o_test_done <= 1'b0;
    end else begin
      if (issue) begin
        o_msg_valid <= 1'b1;
        o_msg_no    <= issue_no;
        rsp_nak_q   <= issue_nak;
        rsp_tmo_q   <= issue_tmo;
      end else if (i_msg_done) begin
        o_msg_valid <= 1'b0;
      end
      o_nak_sent <= issue && issue_nak;
      if (state_q == ST_IDLE) begin
        o_test_done <= i_force_exit;
      end else begin
        o_test_done <= o_test_done || i_force_exit || nak_rx || (state_d == ST_DONE);
      end
    end
  end

`ifdef PM_RX_NAK_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_nak_cnt <= '0;
    end else if (issue && issue_nak && (o_nak_cnt != 8'hFF)) begin
      o_nak_cnt <= o_nak_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pm_entry_rx_gen.sv
// Self-checking bench for pm_entry_rx_gen: directed flows plus randomized
// traffic compared every cycle against an event-level reference model.
module tb_pm_entry_rx_gen;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic       i_en = 1'b0;
  logic       i_req_L1_or_L2 = 1'b0;
  logic [1:0] i_clk_div_ratio = 2'd0;
  logic       i_force_exit = 1'b0;
  logic       i_msg_valid = 1'b0;
  logic [3:0] i_msg_no = 4'd0;
  logic       i_msg_done = 1'b0;
  logic       o_msg_valid;
  logic [3:0] o_msg_no;
  logic       o_test_done;
  logic       o_nak_sent;
`ifdef PM_RX_NAK_CNT_EN
  logic [7:0] o_nak_cnt;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #5 i_clk = ~i_clk;

  pm_entry_rx_gen dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_en            (i_en),
    .i_req_L1_or_L2  (i_req_L1_or_L2),
    .i_clk_div_ratio (i_clk_div_ratio),
    .i_force_exit    (i_force_exit),
    .i_msg_valid     (i_msg_valid),
    .i_msg_no        (i_msg_no),
    .i_msg_done      (i_msg_done),
    .o_msg_valid     (o_msg_valid),
    .o_msg_no        (o_msg_no),
    .o_test_done     (o_test_done),
    .o_nak_sent      (o_nak_sent)
`ifdef PM_RX_NAK_CNT_EN
    ,
    .o_nak_cnt       (o_nak_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: phases of the flow, with the timeout as an absolute deadline
  localparam int P_IDLE = 0, P_WAIT = 1, P_SEND = 2, P_DONE = 3;
  int       m_ph = P_IDLE;
  int       m_edge = 0;
  int       m_dl = 0;
  int       m_lim = 0;
  bit       m_lat = 0, m_kind = 0, m_tmo = 0, m_nak = 0;
  bit       m_valid = 0, m_td = 0, m_nak_sent = 0;
  int       m_no = 0;
  int       m_nak_cnt = 0;
  int       nph;
  bit       req_in, issue, isnak, istmo, clr;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_ph = P_IDLE; m_lat = 0; m_kind = 0; m_tmo = 0; m_nak = 0;
      m_valid = 0; m_td = 0; m_nak_sent = 0; m_no = 0; m_nak_cnt = 0;
      m_dl = 0; m_lim = 0;
    end else begin
      m_edge++;
      req_in = i_msg_valid && (i_msg_no == 4'd2 || i_msg_no == 4'd3);
      issue = 0; isnak = 0; istmo = 0; clr = 0; nph = m_ph;
      case (m_ph)
        P_IDLE: if (i_en) nph = P_WAIT;
                else if (m_lat && m_edge == m_dl) begin issue = 1; isnak = 1; istmo = 1; end
        P_WAIT: if (!i_en) begin nph = P_IDLE; clr = 1; end
                else if (m_lat) begin issue = 1; isnak = (m_kind != i_req_L1_or_L2); end
        P_SEND: if (!i_en && !m_tmo) nph = P_IDLE;
                else if (!m_valid) nph = P_DONE;
        default: if (!i_en || m_nak) nph = P_IDLE;
      endcase
      if (issue) begin
        nph = P_SEND; clr = 1; m_tmo = istmo; m_nak = isnak;
        m_no = isnak ? 9 : (m_kind ? 11 : 10);
        if (isnak && m_nak_cnt < 255) m_nak_cnt++;
      end
      m_nak_sent = issue && isnak;
      if (issue) m_valid = 1; else if (i_msg_done) m_valid = 0;
      if (m_ph == P_IDLE) m_td = i_force_exit;
      else m_td = m_td | i_force_exit | (i_msg_valid && i_msg_no == 4'd9) | (nph == P_DONE);
      if (req_in) begin
        m_lat = 1; m_kind = (i_msg_no == 4'd3); m_lim = 100 << i_clk_div_ratio;
      end else if (clr) m_lat = 0;
      if (nph == P_IDLE && m_lat && (req_in || m_ph != P_IDLE)) m_dl = m_edge + m_lim;
      m_ph = nph;
    end
  end

  always @(negedge i_clk) begin
    if (chk_on) begin
      chk("cmp_valid", o_msg_valid, m_valid);
      chk("cmp_msg_no", o_msg_no, m_no);
      chk("cmp_test_done", o_test_done, m_td);
      chk("cmp_nak_sent", o_nak_sent, m_nak_sent);
`ifdef PM_RX_NAK_CNT_EN
      chk("cmp_nak_cnt", o_nak_cnt, m_nak_cnt);
`endif
    end
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_msg(input logic [3:0] id);
    i_msg_valid = 1'b1; i_msg_no = id;
    cyc();
    i_msg_valid = 1'b0;
  endtask

  task automatic wait_nak(output int n);
    n = 0;
    while (n < 1000) begin
      cyc();
      n++;
      if (o_nak_sent) break;
    end
  endtask

  task automatic finish_rsp();
    i_msg_done = 1'b1;
    cyc();
    i_msg_done = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic do_reset();
    i_en = 1'b0; i_msg_valid = 1'b0; i_msg_done = 1'b0; i_force_exit = 1'b0;
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    #2 i_rst_n = 1'b1;
    cyc();
  endtask

  logic [3:0] ids [5] = '{4'd2, 4'd3, 4'd9, 4'd5, 4'd10};
  int         n;
  int         rate;

  initial begin
    #2 i_rst_n = 1'b0;
    chk_on = 1'b1;
    repeat (2) @(negedge i_clk);
    #2 i_rst_n = 1'b1;
    cyc();
    chk("rst_valid", o_msg_valid, 0);
    chk("rst_msg_no", o_msg_no, 0);
    chk("rst_test_done", o_test_done, 0);
    chk("rst_nak_sent", o_nak_sent, 0);

    // remote Req L1 before enable, local L1 -> Rsp L1
    send_msg(4'd2);
    repeat (4) cyc();
    i_en = 1'b1;
    cyc();
    cyc();
    chk("l1_valid", o_msg_valid, 1);
    chk("l1_msg_no", o_msg_no, 10);
    chk("l1_model_no", m_no, 10);
    chk("l1_nak_sent", o_nak_sent, 0);
    repeat (3) cyc();
    chk("l1_valid_hold", o_msg_valid, 1);
    i_msg_done = 1'b1;
    cyc();
    i_msg_done = 1'b0;
    chk("l1_valid_drop", o_msg_valid, 0);
    chk("l1_done_early", o_test_done, 0);
    cyc();
    chk("l1_test_done", o_test_done, 1);
    i_en = 1'b0;
    repeat (2) cyc();
    chk("l1_done_clear", o_test_done, 0);

    // remote Req L2, local L1 -> PMNAK
    send_msg(4'd3);
    i_en = 1'b1;
    cyc();
    cyc();
    chk("mm_valid", o_msg_valid, 1);
    chk("mm_msg_no", o_msg_no, 9);
    chk("mm_nak_sent", o_nak_sent, 1);
    cyc();
    chk("mm_nak_pulse_end", o_nak_sent, 0);
    i_msg_done = 1'b1;
    cyc();
    i_msg_done = 1'b0;
    cyc();
    chk("mm_test_done", o_test_done, 1);
    cyc();
    i_en = 1'b0;
    cyc();
    chk("mm_done_clear", o_test_done, 0);

    // timeout NAK with ratio 1 and 2; ratio change mid-count is ignored
    i_clk_div_ratio = 2'd1;
    send_msg(4'd2);
    wait_nak(n);
    chk("tmo_r1_cycles", n, 200);
    chk("tmo_r1_msg_no", o_msg_no, 9);
    finish_rsp();
    i_clk_div_ratio = 2'd2;
    send_msg(4'd2);
    i_clk_div_ratio = 2'd0;
    wait_nak(n);
    chk("tmo_r2_cycles", n, 400);
    finish_rsp();
    chk("tmo_done_clear", o_test_done, 0);

    // PMNAK received in WAIT_REQ
    i_en = 1'b1;
    cyc();
    send_msg(4'd9);
    chk("rxnak_test_done", o_test_done, 1);
    i_en = 1'b0;
    repeat (2) cyc();
    chk("rxnak_clear", o_test_done, 0);

    // force exit in SEND_RSP, then async reset mid-valid
    send_msg(4'd2);
    i_en = 1'b1;
    cyc();
    cyc();
    chk("fx_valid", o_msg_valid, 1);
    chk("fx_before", o_test_done, 0);
    i_force_exit = 1'b1;
    cyc();
    i_force_exit = 1'b0;
    chk("fx_test_done", o_test_done, 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_valid", o_msg_valid, 0);
    chk("arst_msg_no", o_msg_no, 0);
    chk("arst_test_done", o_test_done, 0);
    chk("arst_nak_sent", o_nak_sent, 0);
    i_en = 1'b0;
    @(negedge i_clk);
    #2 i_rst_n = 1'b1;
    cyc();

    // randomized traffic: fast then slow enable toggling
    for (int seg = 0; seg < 2; seg++) begin
      rate = (seg == 0) ? 30 : 400;
      for (int i = 0; i < 3500; i++) begin
        if ($urandom_range(0, rate - 1) == 0) i_en = ~i_en;
        if ($urandom_range(0, 49) == 0) i_req_L1_or_L2 = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 199) == 0) i_clk_div_ratio = 2'($urandom_range(0, 1));
        i_msg_valid  = ($urandom_range(0, 24) == 0);
        i_msg_no     = ids[$urandom_range(0, 4)];
        i_msg_done   = ($urandom_range(0, 3) == 0);
        i_force_exit = ($urandom_range(0, 99) == 0);
        cyc();
      end
    end
    i_msg_valid = 1'b0; i_msg_done = 1'b0; i_force_exit = 1'b0;

`ifdef PM_RX_NAK_CNT_EN
    do_reset();
    chk("cnt_after_rst", o_nak_cnt, 0);
    i_clk_div_ratio = 2'd0;
    for (int k = 0; k < 300; k++) begin
      send_msg(4'd2);
      wait_nak(n);
      chk("cnt_tmo_cycles", n, 100);
      finish_rsp();
    end
    chk("cnt_saturated", o_nak_cnt, 255);
`else
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
